// File: rtl/bttn_pkg.sv
// Shared definitions for the button-driven operand sequencer: operand widths
// and the state encoding that is also shown on the state LEDs.
package bttn_pkg;

  localparam int A_W   = 4;
  localparam int B_W   = 4;
  localparam int OP_W  = 3;
  localparam int SEL_W = 2;
  localparam int Y_W   = 12;
  localparam int ST_W  = 3;

  localparam logic [ST_W-1:0] ST_ENT_A   = 3'd0;
  localparam logic [ST_W-1:0] ST_ENT_B   = 3'd1;
  localparam logic [ST_W-1:0] ST_ENT_OP  = 3'd2;
  localparam logic [ST_W-1:0] ST_ENT_SEL = 3'd3;
  localparam logic [ST_W-1:0] ST_EXEC    = 3'd4;
  localparam logic [ST_W-1:0] ST_SHOW    = 3'd5;

  typedef enum logic [ST_W-1:0] {
    ENT_A   = ST_ENT_A,
    ENT_B   = ST_ENT_B,
    ENT_OP  = ST_ENT_OP,
    ENT_SEL = ST_ENT_SEL,
    EXEC    = ST_EXEC,
    SHOW    = ST_SHOW
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes one raw active-low button, debounces it and emits a single
// one-cycle press event per accepted released->pressed transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Internal polarity is active-high: 1 means pressed.
  logic [1:0]       sync_q,  sync_d;
  logic [2:0]       fill_q,  fill_d;   // marks when sync/sample flops hold real samples
  logic             samp_q,  samp_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             level_q, level_d;
  logic             armed_q, armed_d;  // set once a stable release has been seen
  logic             press_q, press_d;

  // Debounce: count consecutive equal samples, accept the level after
  // DEBOUNCE_CYCLES of them; only an armed button may produce a press.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    sync_d  = {sync_q[0], ~btn_n};
    fill_d  = {fill_q[1:0], 1'b1};
    samp_d  = sync_q[1];
    cnt_d   = cnt_q;
    level_d = level_q;
    armed_d = armed_q;

    if (!fill_q[2] || (sync_q[1] != samp_q)) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (fill_q[2] && (cnt_q == CNT_MAX)) begin
      level_d = samp_q;
      if (!samp_q) begin
        armed_d = 1'b1;
      end
    end

    press_d = level_d & ~level_q & armed_q;
  end

  // State register for synchronizer, counter, stable level and press event.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    if (!rst_n) begin
      sync_q  <= '0;
      fill_q  <= '0;
      samp_q  <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      fill_q  <= fill_d;
      samp_q  <= samp_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/bttn_seq.sv
// Button-driven operand entry sequencer: the user keys in A, B, opcode and
// select with the switches, the datapath result is captured and displayed.
module bttn_seq
  import bttn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_next_n,
  input  logic             btn_back_n,
  input  logic [A_W-1:0]   sw,
  input  logic [Y_W-1:0]   y_in,
  output logic [A_W-1:0]   a_out,
  output logic [B_W-1:0]   b_out,
  output logic [OP_W-1:0]  op_out,
  output logic [SEL_W-1:0] sel_out,
  output logic [Y_W-1:0]   result,
  output logic             result_valid,
  output logic [ST_W-1:0]  state_led
);

  localparam int SC_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [SC_W-1:0] SETTLE_MAX = SC_W'(SETTLE_CYCLES);

  logic next_press, back_press;
  logic next_level, back_level;
  logic next_ev, back_ev;

  state_e           state_q, state_d;
  logic [A_W-1:0]   a_q,     a_d;
  logic [B_W-1:0]   b_q,     b_d;
  logic [OP_W-1:0]  op_q,    op_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic [Y_W-1:0]   res_q,   res_d;
  logic             vld_q,   vld_d;
  logic [SC_W-1:0]  cnt_q,   cnt_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_next_n),
    .level (next_level),
    .press (next_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_back_n),
    .level (back_level),
    .press (back_press)
  );

  // Stable levels are not needed here; only the press events drive the FSM.
  logic unused_levels;
  assign unused_levels = next_level ^ back_level;

  // Simultaneous next and back cancel each other.
  assign next_ev = next_press & ~back_press;
  assign back_ev = back_press & ~next_press;

  // Next-state and register-update logic of the sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sel_d   = sel_q;
    res_d   = res_q;
    vld_d   = vld_q;
    cnt_d   = '0;

    case (state_q)
      ENT_A: begin
        if (next_ev) begin
          a_d     = sw;
          state_d = ENT_B;
        end
      end
      ENT_B: begin
        if (next_ev) begin
          b_d     = sw;
          state_d = ENT_OP;
        end else if (back_ev) begin
          state_d = ENT_A;
        end
      end
      ENT_OP: begin
        if (next_ev) begin
          op_d    = sw[OP_W-1:0];
          state_d = ENT_SEL;
        end else if (back_ev) begin
          state_d = ENT_B;
        end
      end
      ENT_SEL: begin
        if (next_ev) begin
          sel_d   = sw[SEL_W-1:0];
          state_d = EXEC;
        end else if (back_ev) begin
          state_d = ENT_OP;
        end
      end
      EXEC: begin
        // Let the datapath settle, then capture on the following edge.
        if (cnt_q == SETTLE_MAX) begin
          res_d   = y_in;
          vld_d   = 1'b1;
          state_d = SHOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHOW: begin
        if (next_ev) begin
          vld_d   = 1'b0;
          state_d = ENT_A;
        end else if (back_ev) begin
          vld_d   = 1'b0;
          state_d = ENT_SEL;
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = ENT_A;
      end
    endcase
  end

  // Sequencer state and operand/result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign a_out        = a_q;
  assign b_out        = b_q;
  assign op_out       = op_q;
  assign sel_out      = sel_q;
  assign result       = res_q;
  assign result_valid = vld_q;
  assign state_led    = state_q;

endmodule

// File: tb/tb_bttn_seq.sv
// Self-checking bench for bttn_seq: expected snapshots are queued when a
// stimulus is driven and compared once the sequencer has reacted.
module tb_bttn_seq;
  import bttn_pkg::*;

  localparam int DEB = 4;
  localparam int SET = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_next_n;
  logic        btn_back_n;
  logic [3:0]  sw;
  logic [11:0] y_in;
  logic [3:0]  a_out;
  logic [3:0]  b_out;
  logic [2:0]  op_out;
  logic [1:0]  sel_out;
  logic [11:0] result;
  logic        result_valid;
  logic [2:0]  state_led;

  typedef struct packed {
    logic [2:0]  st;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [2:0]  op;
    logic [1:0]  sel;
    logic [11:0] res;
    logic        v;
  } snap_t;

  snap_t sb[$];
  int    checks = 0;
  int    passed = 0;

  // Observations from the last run_press call.
  int         n_chg;
  int         chg_cyc [8];
  logic [2:0] chg_st  [8];
  int         v_cyc;

  always #5 clk = ~clk;

  bttn_seq #(
    .DEBOUNCE_CYCLES (DEB),
    .SETTLE_CYCLES   (SET)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_next_n   (btn_next_n),
    .btn_back_n   (btn_back_n),
    .sw           (sw),
    .y_in         (y_in),
    .a_out        (a_out),
    .b_out        (b_out),
    .op_out       (op_out),
    .sel_out      (sel_out),
    .result       (result),
    .result_valid (result_valid),
    .state_led    (state_led)
  );

  // Datapath model feeding y_in.
  function automatic logic [11:0] y_model(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op, input logic [1:0] sel);
    logic [11:0] aa, bb;
    aa = {8'h00, a};
    bb = {8'h00, b};
    case (sel)
      2'd0:    y_model = aa * bb;
      2'd1:    y_model = aa + bb;
      2'd2:    y_model = {op, a, b, 1'b0};
      default: y_model = aa - bb;
    endcase
  endfunction

  always_comb y_in = y_model(a_out, b_out, op_out, sel_out);

  function automatic snap_t mk(input logic [2:0] st, input logic [3:0] a, input logic [3:0] b,
                               input logic [2:0] op, input logic [1:0] sel,
                               input logic [11:0] res, input logic v);
    snap_t s;
    s.st = st; s.a = a; s.b = b; s.op = op; s.sel = sel; s.res = res; s.v = v;
    return s;
  endfunction

  function automatic snap_t observe();
    return mk(state_led, a_out, b_out, op_out, sel_out, result, result_valid);
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("st=%0d a=%h b=%h op=%h sel=%h res=%h v=%b",
                     s.st, s.a, s.b, s.op, s.sel, s.res, s.v);
  endfunction

  // Drive one or both buttons low for `hold` cycles within a `budget`-cycle
  // window, recording every state change; optionally pulse reset in EXEC.
  task automatic run_press(input logic nxt, input logic bck, input int hold,
                           input int budget, input bit rst_on_exec);
    logic [2:0] last;
    bit         did_rst;
    did_rst = 1'b0;
    n_chg   = 0;
    v_cyc   = -1;
    last    = state_led;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state_led !== last) begin
        if (n_chg < 8) begin
          chg_cyc[n_chg] = i;
          chg_st[n_chg]  = state_led;
        end
        n_chg++;
        last = state_led;
      end
      if (result_valid === 1'b1 && v_cyc < 0) v_cyc = i;
      btn_next_n = !(nxt && (i < hold));
      btn_back_n = !(bck && (i < hold));
      if (rst_on_exec && !did_rst && state_led == ST_EXEC) begin
        rst_n   = 1'b0;
        did_rst = 1'b1;
      end else begin
        rst_n = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    snap_t e, o;
    rst_n = 1'b0; btn_next_n = 1'b1; btn_back_n = 1'b1; sw = 4'h0;
    repeat (3) @(negedge clk);
    sb.push_back(mk(ST_ENT_A, 4'h0, 4'h0, 3'h0, 2'h0, 12'h000, 1'b0));
    o = observe(); e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL reset_asserted: observed %s expected %s", fmt(o), fmt(e));
    else passed++;
    rst_n = 1'b1;
    sb.push_back(mk(ST_ENT_A, 4'h0, 4'h0, 3'h0, 2'h0, 12'h000, 1'b0));
    repeat (12) @(negedge clk);
    o = observe(); e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL reset_released: observed %s expected %s", fmt(o), fmt(e));
    else passed++;
  endtask

  task automatic test_back_in_ent_a();
    snap_t e, o;
    sw = 4'hF;
    sb.push_back(mk(ST_ENT_A, 4'h0, 4'h0, 3'h0, 2'h0, 12'h000, 1'b0));
    run_press(1'b0, 1'b1, 10, 30, 1'b0);
    checks++;
    if (n_chg !== 0) $display("FAIL back_in_ent_a_changes: observed %0d expected 0", n_chg);
    else passed++;
    o = observe(); e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL back_in_ent_a: observed %s expected %s", fmt(o), fmt(e));
    else passed++;
  endtask

  task automatic test_glitch();
    snap_t e, o;
    sw = 4'hF;
    sb.push_back(mk(ST_ENT_A, 4'h0, 4'h0, 3'h0, 2'h0, 12'h000, 1'b0));
    run_press(1'b1, 1'b0, 3, 30, 1'b0);
    checks++;
    if (n_chg !== 0) $display("FAIL glitch_changes: observed %0d expected 0", n_chg);
    else passed++;
    o = observe(); e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL glitch: observed %s expected %s", fmt(o), fmt(e));
    else passed++;
  endtask

  task automatic test_hold();
    snap_t e, o;
    sw = 4'hF;
    sb.push_back(mk(ST_ENT_B, 4'hF, 4'h0, 3'h0, 2'h0, 12'h000, 1'b0));
    run_press(1'b1, 1'b0, 10, 30, 1'b0);
    checks++;
    if (n_chg !== 1) $display("FAIL hold_changes: observed %0d expected 1", n_chg);
    else passed++;
    o = observe(); e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL hold_next: observed %s expected %s", fmt(o), fmt(e));
    else passed++;
  endtask

  task automatic test_both();
    snap_t e, o;
    sw = 4'h3;
    sb.push_back(mk(ST_ENT_B, 4'hF, 4'h0, 3'h0, 2'h0, 12'h000, 1'b0));
    run_press(1'b1, 1'b1, 10, 30, 1'b0);
    checks++;
    if (n_chg !== 0) $display("FAIL both_changes: observed %0d expected 0", n_chg);
    else passed++;
    o = observe(); e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL both_buttons: observed %s expected %s", fmt(o), fmt(e));
    else passed++;
  endtask

  task automatic test_back();
    snap_t e, o;
    sw = 4'hF;
    sb.push_back(mk(ST_ENT_OP, 4'hF, 4'hF, 3'h0, 2'h0, 12'h000, 1'b0));
    run_press(1'b1, 1'b0, 10, 30, 1'b0);
    o = observe(); e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL next_to_ent_op: observed %s expected %s", fmt(o), fmt(e));
    else passed++;
    sw = 4'h5;
    sb.push_back(mk(ST_ENT_B, 4'hF, 4'hF, 3'h0, 2'h0, 12'h000, 1'b0));
    run_press(1'b0, 1'b1, 10, 30, 1'b0);
    checks++;
    if (n_chg !== 1) $display("FAIL back_changes: observed %0d expected 1", n_chg);
    else passed++;
    o = observe(); e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL back_to_ent_b: observed %s expected %s", fmt(o), fmt(e));
    else passed++;
    sw = 4'hF;
    sb.push_back(mk(ST_ENT_OP, 4'hF, 4'hF, 3'h0, 2'h0, 12'h000, 1'b0));
    run_press(1'b1, 1'b0, 10, 30, 1'b0);
    o = observe(); e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL renext_to_ent_op: observed %s expected %s", fmt(o), fmt(e));
    else passed++;
  endtask

  task automatic test_exec();
    snap_t e, o;
    sw = 4'h0;
    sb.push_back(mk(ST_ENT_SEL, 4'hF, 4'hF, 3'h0, 2'h0, 12'h000, 1'b0));
    run_press(1'b1, 1'b0, 10, 30, 1'b0);
    o = observe(); e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL next_to_ent_sel: observed %s expected %s", fmt(o), fmt(e));
    else passed++;
    sw = 4'h1;
    sb.push_back(mk(ST_SHOW, 4'hF, 4'hF, 3'h0, 2'h1, 12'h01E, 1'b1));
    run_press(1'b1, 1'b0, 10, 40, 1'b0);
    checks++;
    if (n_chg !== 2) $display("FAIL exec_changes: observed %0d expected 2", n_chg);
    else passed++;
    checks++;
    if (n_chg < 1 || chg_st[0] !== ST_EXEC)
      $display("FAIL exec_entry: observed changes=%0d first_state=%0d expected state 4", n_chg, chg_st[0]);
    else passed++;
    checks++;
    if (n_chg < 2 || chg_st[1] !== ST_SHOW || (chg_cyc[1] - chg_cyc[0]) !== 3)
      $display("FAIL exec_to_show: observed changes=%0d second_state=%0d gap=%0d expected state 5 gap 3",
               n_chg, chg_st[1], chg_cyc[1] - chg_cyc[0]);
    else passed++;
    checks++;
    if (n_chg < 1 || v_cyc < 0 || (v_cyc - chg_cyc[0]) !== 3)
      $display("FAIL valid_latency: observed valid_cycle=%0d exec_cycle=%0d expected gap 3", v_cyc, chg_cyc[0]);
    else passed++;
    o = observe(); e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL exec_capture: observed %s expected %s", fmt(o), fmt(e));
    else passed++;
  endtask

  task automatic test_show_next();
    snap_t e, o;
    sw = 4'h7;
    sb.push_back(mk(ST_ENT_A, 4'hF, 4'hF, 3'h0, 2'h1, 12'h01E, 1'b0));
    run_press(1'b1, 1'b0, 10, 30, 1'b0);
    checks++;
    if (n_chg !== 1) $display("FAIL show_next_changes: observed %0d expected 1", n_chg);
    else passed++;
    o = observe(); e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL show_next: observed %s expected %s", fmt(o), fmt(e));
    else passed++;
  endtask

  task automatic test_reset_in_exec();
    snap_t e, o;
    sw = 4'h2; run_press(1'b1, 1'b0, 10, 30, 1'b0);
    sw = 4'h3; run_press(1'b1, 1'b0, 10, 30, 1'b0);
    sw = 4'h1; run_press(1'b1, 1'b0, 10, 30, 1'b0);
    sb.push_back(mk(ST_ENT_SEL, 4'h2, 4'h3, 3'h1, 2'h1, 12'h01E, 1'b0));
    o = observe(); e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL setup_ent_sel: observed %s expected %s", fmt(o), fmt(e));
    else passed++;
    // Button stays held across the reset pulse; no event may follow it.
    sw = 4'h2;
    sb.push_back(mk(ST_ENT_A, 4'h0, 4'h0, 3'h0, 2'h0, 12'h000, 1'b0));
    run_press(1'b1, 1'b0, 40, 70, 1'b1);
    checks++;
    if (n_chg !== 2 || chg_st[0] !== ST_EXEC || chg_st[1] !== ST_ENT_A)
      $display("FAIL exec_reset_path: observed changes=%0d states=%0d,%0d expected 2 changes 4,0",
               n_chg, chg_st[0], chg_st[1]);
    else passed++;
    checks++;
    if (v_cyc !== -1) $display("FAIL exec_reset_capture: observed valid at cycle %0d expected none", v_cyc);
    else passed++;
    o = observe(); e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL exec_reset: observed %s expected %s", fmt(o), fmt(e));
    else passed++;
  endtask

  task automatic test_rearm();
    snap_t e, o;
    sw = 4'h9;
    sb.push_back(mk(ST_ENT_B, 4'h9, 4'h0, 3'h0, 2'h0, 12'h000, 1'b0));
    run_press(1'b1, 1'b0, 10, 30, 1'b0);
    o = observe(); e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL rearm_next: observed %s expected %s", fmt(o), fmt(e));
    else passed++;
  endtask

  initial begin
    test_reset();
    test_back_in_ent_a();
    test_glitch();
    test_hold();
    test_both();
    test_back();
    test_exec();
    test_show_next();
    test_reset_in_exec();
    test_rearm();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
